// File: rtl/turfio_bidir_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : turfio_bidir_link                                            |
// | Description : SURF-side endpoint of the TURFIO RACKCTL single-wire link.   |
// |               Receives a preamble-framed command word and hands it to      |
// |               fabric. Then turns the pair around, sends a postamble-framed |
// |               response (echo or user word), and releases the pair.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   rxclk_i        link clock; all logic runs on it                          |
// |   rst_n_i        synchronous active-low reset                              |
// |   rackctl_in_i   raw receive bit from the IOB O output                     |
// |   rackctl_out_o  registered transmit bit to the IOB I input (INV applied)  |
// |   rackctl_tri_o  registered IOB T input, 1 = tristate                      |
// |   cmd_dat_o      last received command word                                |
// |   cmd_valid_o    one-cycle strobe when cmd_dat_o updates                   |
// |   resp_dat_i     response word (ignored when ECHO=1)                       |
// |   resp_valid_i   response offered                                          |
// |   resp_ready_o   waiting for a response; transfer on valid & ready         |
// |   busy_o         frame in progress, DATA through TURN_1                    |
// |   framing_err_o  one-cycle strobe on a preamble mismatch                   |
// |   err_count_o    saturating framing error count                            |
// +----------------------------------------------------------------------------+
module turfio_bidir_link #(
  parameter logic INV        = 1'b0,
  parameter int   DATA_BITS  = 32,
  parameter int   TURNAROUND = 128,
  parameter logic ECHO       = 1'b0
) (
  input  logic                 rxclk_i,
  input  logic                 rst_n_i,
  input  logic                 rackctl_in_i,
  output logic                 rackctl_out_o,
  output logic                 rackctl_tri_o,
  output logic [DATA_BITS-1:0] cmd_dat_o,
  output logic                 cmd_valid_o,
  input  logic [DATA_BITS-1:0] resp_dat_i,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  output logic                 busy_o,
  output logic                 framing_err_o,
  output logic [7:0]           err_count_o
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRE_0     = 4'd1,
    ST_PRE_1     = 4'd2,
    ST_PRE_2     = 4'd3,
    ST_DATA      = 4'd4,
    ST_TURN_0    = 4'd5,
    ST_WAIT_RESP = 4'd6,
    ST_POST      = 4'd7,
    ST_RESP      = 4'd8,
    ST_TURN_1    = 4'd9
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(DATA_BITS - 1);
  localparam logic [15:0] TURN_LAST = 16'(TURNAROUND - 1);
  // Postamble, sent MSB first: 1,1,1,0
  localparam logic [3:0]  POST_PAT  = 4'b1110;
  localparam logic        IDLE_BIT  = 1'b1 ^ INV;

  state_t               state_q;
  logic                 in_ff_q;
  logic                 in_rr_q;
  logic                 in_en;
  logic [15:0]          cnt_q;
  logic [DATA_BITS-1:0] rx_sr_q;
  logic [DATA_BITS-1:0] tx_sr_q;
  logic [DATA_BITS-1:0] cmd_dat_q;
  logic                 cmd_valid_q;
  logic                 out_q;
  logic                 tri_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 ferr_q;
  logic [7:0]           ecnt_q;

  // The input flop only samples while the far end owns the pair; once we
  // start driving, it holds its last value.
  assign in_en = (state_q == ST_IDLE)  || (state_q == ST_PRE_0) ||
                 (state_q == ST_PRE_1) || (state_q == ST_PRE_2) ||
                 (state_q == ST_DATA);

  always_ff @(posedge rxclk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      in_ff_q     <= 1'b1;
      in_rr_q     <= 1'b1;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      cmd_dat_q   <= '0;
      cmd_valid_q <= 1'b0;
      out_q       <= IDLE_BIT;
      tri_q       <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ecnt_q      <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      in_rr_q     <= in_ff_q;
      if (in_en) begin
        in_ff_q <= rackctl_in_i ^ INV;
      end
      // Counter runs freely; every transition below clears it.
      cnt_q <= cnt_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (!in_ff_q && in_rr_q) begin
            state_q <= ST_PRE_0;
            cnt_q   <= '0;
          end
        end
        ST_PRE_0, ST_PRE_1, ST_PRE_2: begin
          // Expected preamble bits after the leading 0: 1, 0, 1
          if (in_ff_q == (state_q != ST_PRE_1)) begin
            cnt_q <= '0;
            if (state_q == ST_PRE_0) begin
              state_q <= ST_PRE_1;
            end else if (state_q == ST_PRE_1) begin
              state_q <= ST_PRE_2;
            end else begin
              state_q <= ST_DATA;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ferr_q  <= 1'b1;
            if (ecnt_q != 8'hFF) begin
              ecnt_q <= ecnt_q + 8'd1;
            end
          end
        end
        ST_DATA: begin
          rx_sr_q <= {rx_sr_q[DATA_BITS-2:0], in_ff_q};
          if (cnt_q == BIT_LAST) begin
            cmd_dat_q   <= {rx_sr_q[DATA_BITS-2:0], in_ff_q};
            cmd_valid_q <= 1'b1;
            state_q     <= ST_TURN_0;
            cnt_q       <= '0;
          end
        end
        ST_TURN_0: begin
          if (cnt_q == TURN_LAST) begin
            state_q <= ST_WAIT_RESP;
            cnt_q   <= '0;
            tri_q   <= 1'b0;
            out_q   <= IDLE_BIT;
            ready_q <= !ECHO;
          end
        end
        ST_WAIT_RESP: begin
          out_q <= IDLE_BIT;
          if (ECHO) begin
            tx_sr_q <= cmd_dat_q;
            state_q <= ST_POST;
            cnt_q   <= '0;
          end else if (resp_valid_i && ready_q) begin
            tx_sr_q <= resp_dat_i;
            ready_q <= 1'b0;
            state_q <= ST_POST;
            cnt_q   <= '0;
          end
        end
        ST_POST: begin
          out_q <= POST_PAT[2'd3 - cnt_q[1:0]] ^ INV;
          if (cnt_q[1:0] == 2'd3) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
          end
        end
        ST_RESP: begin
          out_q   <= tx_sr_q[DATA_BITS-1] ^ INV;
          tx_sr_q <= tx_sr_q << 1;
          if (cnt_q == BIT_LAST) begin
            state_q <= ST_TURN_1;
            cnt_q   <= '0;
          end
        end
        ST_TURN_1: begin
          out_q <= IDLE_BIT;
          if (cnt_q == TURN_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tri_q   <= 1'b1;
            busy_q  <= 1'b0;
            // Stale frozen samples must not look like a start edge.
            in_ff_q <= 1'b1;
            in_rr_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rackctl_out_o = out_q;
  assign rackctl_tri_o = tri_q;
  assign cmd_dat_o     = cmd_dat_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign resp_ready_o  = ready_q;
  assign busy_o        = busy_q;
  assign framing_err_o = ferr_q;
  assign err_count_o   = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_turfio_bidir_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_turfio_bidir_link                                         |
// | Description : Directed self-checking bench for turfio_bidir_link. Three   |
// |               instances: echo (32b, T=128), user response (32b, T=128),    |
// |               and inverted narrow (8b, T=2, INV=1).                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_turfio_bidir_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sel;
  logic        wire_bit;
  logic        in_e, in_u, in_v;
  logic [31:0] resp_dat_u;
  logic        resp_valid_u;

  // Unselected pairs sit at their idle wire level.
  assign in_e = (sel == 2'd0) ? wire_bit : 1'b1;
  assign in_u = (sel == 2'd1) ? wire_bit : 1'b1;
  assign in_v = (sel == 2'd2) ? wire_bit : 1'b0;

  logic        e_out, e_tri, e_valid, e_ready, e_busy, e_ferr;
  logic [31:0] e_cmd;
  logic [7:0]  e_ecnt;
  logic        u_out, u_tri, u_valid, u_ready, u_busy, u_ferr;
  logic [31:0] u_cmd;
  logic [7:0]  u_ecnt;
  logic        v_out, v_tri, v_valid, v_ready, v_busy, v_ferr;
  logic [7:0]  v_cmd;
  logic [7:0]  v_ecnt;

  turfio_bidir_link #(.INV(1'b0), .DATA_BITS(32), .TURNAROUND(128), .ECHO(1'b1)) u_echo (
    .rxclk_i(clk), .rst_n_i(rst_n), .rackctl_in_i(in_e),
    .rackctl_out_o(e_out), .rackctl_tri_o(e_tri),
    .cmd_dat_o(e_cmd), .cmd_valid_o(e_valid),
    .resp_dat_i(32'h0), .resp_valid_i(1'b0), .resp_ready_o(e_ready),
    .busy_o(e_busy), .framing_err_o(e_ferr), .err_count_o(e_ecnt));

  turfio_bidir_link #(.INV(1'b0), .DATA_BITS(32), .TURNAROUND(128), .ECHO(1'b0)) u_user (
    .rxclk_i(clk), .rst_n_i(rst_n), .rackctl_in_i(in_u),
    .rackctl_out_o(u_out), .rackctl_tri_o(u_tri),
    .cmd_dat_o(u_cmd), .cmd_valid_o(u_valid),
    .resp_dat_i(resp_dat_u), .resp_valid_i(resp_valid_u), .resp_ready_o(u_ready),
    .busy_o(u_busy), .framing_err_o(u_ferr), .err_count_o(u_ecnt));

  turfio_bidir_link #(.INV(1'b1), .DATA_BITS(8), .TURNAROUND(2), .ECHO(1'b1)) u_inv (
    .rxclk_i(clk), .rst_n_i(rst_n), .rackctl_in_i(in_v),
    .rackctl_out_o(v_out), .rackctl_tri_o(v_tri),
    .cmd_dat_o(v_cmd), .cmd_valid_o(v_valid),
    .resp_dat_i(8'h0), .resp_valid_i(1'b0), .resp_ready_o(v_ready),
    .busy_o(v_busy), .framing_err_o(v_ferr), .err_count_o(v_ecnt));

  // View of the currently selected instance.
  logic        s_out, s_tri, s_valid, s_ready, s_busy, s_ferr;
  logic [63:0] s_cmd;
  logic [7:0]  s_ecnt;
  always_comb begin
    s_out = e_out; s_tri = e_tri; s_valid = e_valid; s_ready = e_ready;
    s_busy = e_busy; s_ferr = e_ferr; s_cmd = {32'h0, e_cmd}; s_ecnt = e_ecnt;
    case (sel)
      2'd1: begin
        s_out = u_out; s_tri = u_tri; s_valid = u_valid; s_ready = u_ready;
        s_busy = u_busy; s_ferr = u_ferr; s_cmd = {32'h0, u_cmd}; s_ecnt = u_ecnt;
      end
      2'd2: begin
        s_out = v_out; s_tri = v_tri; s_valid = v_valid; s_ready = v_ready;
        s_busy = v_busy; s_ferr = v_ferr; s_cmd = {56'h0, v_cmd}; s_ecnt = v_ecnt;
      end
      default: ;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr  = 0;
  int n_valid = 0;

  always @(negedge clk) begin
    if (s_ferr)  n_ferr  <= n_ferr + 1;
    if (s_valid) n_valid <= n_valid + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the wire idle at the negedge after D[0] was sampled.
  task automatic send_frame(input logic [63:0] d, input int n, input logic inv);
    logic [3:0] pre;
    pre = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      wire_bit = pre[i] ^ inv;
      @(negedge clk);
    end
    for (int i = n - 1; i >= 0; i--) begin
      wire_bit = d[i] ^ inv;
      @(negedge clk);
    end
    wire_bit = 1'b1 ^ inv;
  endtask

  task automatic expect_cmd(input logic [63:0] d);
    check_val("valid_early", {63'h0, s_valid}, 64'h0);
    @(negedge clk);
    check_val("valid", {63'h0, s_valid}, 64'h1);
    check_val("cmd_dat", s_cmd, d);
  endtask

  task automatic wait_tri_fall(input int t);
    repeat (t - 1) @(negedge clk);
    check_val("tri_hold", {63'h0, s_tri}, 64'h1);
    @(negedge clk);
    check_val("tri_fall", {63'h0, s_tri}, 64'h0);
  endtask

  task automatic read_frame(input int n, input logic inv, output logic [3:0] post,
                            output logic [63:0] word);
    post = 4'h0;
    word = 64'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      post = {post[2:0], s_out ^ inv};
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      word = {word[62:0], s_out ^ inv};
    end
  endtask

  task automatic finish_turn(input int t);
    repeat (t - 1) @(negedge clk);
    check_val("tri_turn1", {63'h0, s_tri}, 64'h0);
    @(negedge clk);
    check_val("tri_rise", {63'h0, s_tri}, 64'h1);
    check_val("busy_idle", {63'h0, s_busy}, 64'h0);
  endtask

  task automatic check_reset_vals(input logic idle_out);
    check_val("rst_tri",   {63'h0, s_tri},   64'h1);
    check_val("rst_out",   {63'h0, s_out},   {63'h0, idle_out});
    check_val("rst_cmd",   s_cmd,            64'h0);
    check_val("rst_valid", {63'h0, s_valid}, 64'h0);
    check_val("rst_ready", {63'h0, s_ready}, 64'h0);
    check_val("rst_busy",  {63'h0, s_busy},  64'h0);
    check_val("rst_ferr",  {63'h0, s_ferr},  64'h0);
    check_val("rst_ecnt",  {56'h0, s_ecnt},  64'h0);
  endtask

  initial begin
    logic [3:0]  post;
    logic [63:0] word;
    int          v0, f0;
    logic        rdy_bad, out_bad;

    sel = 2'd0; wire_bit = 1'b1; rst_n = 1'b0;
    resp_valid_u = 1'b0; resp_dat_u = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      check_reset_vals(k != 2);
    end
    sel = 2'd0; wire_bit = 1'b1; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Echo frame
    v0 = n_valid;
    send_frame(64'hDEADBEEF, 32, 1'b0);
    expect_cmd(64'hDEADBEEF);
    check_val("busy_frame", {63'h0, s_busy}, 64'h1);
    wait_tri_fall(128);
    @(negedge clk);
    check_val("wait_idle_drive", {63'h0, s_out}, 64'h1);
    read_frame(32, 1'b0, post, word);
    check_val("echo_post", {60'h0, post}, 64'hE);
    check_val("echo_word", word, 64'hDEADBEEF);
    finish_turn(128);
    check_val("echo_valid_pulses", 64'(n_valid - v0), 64'h1);

    // User response with late valid
    sel = 2'd1; wire_bit = 1'b1;
    @(negedge clk);
    send_frame(64'h12345678, 32, 1'b0);
    expect_cmd(64'h12345678);
    check_val("ready_turn0", {63'h0, s_ready}, 64'h0);
    wait_tri_fall(128);
    rdy_bad = 1'b0; out_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (s_ready !== 1'b1) rdy_bad = 1'b1;
      if (s_out !== 1'b1) out_bad = 1'b1;
      @(negedge clk);
    end
    check_val("ready_held", {63'h0, rdy_bad}, 64'h0);
    check_val("out_idle_wait", {63'h0, out_bad}, 64'h0);
    resp_dat_u = 32'hA5A5A5A5; resp_valid_u = 1'b1;
    @(negedge clk);
    resp_valid_u = 1'b0;
    check_val("ready_after_xfer", {63'h0, s_ready}, 64'h0);
    check_val("out_hs_cycle", {63'h0, s_out}, 64'h1);
    read_frame(32, 1'b0, post, word);
    check_val("user_post", {60'h0, post}, 64'hE);
    check_val("user_word", word, 64'hA5A5A5A5);
    finish_turn(128);

    // User response offered before WAIT_RESP
    send_frame(64'h0BADF00D, 32, 1'b0);
    resp_dat_u = 32'h600DCAFE; resp_valid_u = 1'b1;
    expect_cmd(64'h0BADF00D);
    check_val("ready_held_off", {63'h0, s_ready}, 64'h0);
    wait_tri_fall(128);
    check_val("ready_first_wait", {63'h0, s_ready}, 64'h1);
    @(negedge clk);
    resp_valid_u = 1'b0;
    check_val("ready_early_xfer", {63'h0, s_ready}, 64'h0);
    read_frame(32, 1'b0, post, word);
    check_val("early_post", {60'h0, post}, 64'hE);
    check_val("early_word", word, 64'h600DCAFE);
    finish_turn(128);

    // Framing errors on the echo instance
    sel = 2'd0; wire_bit = 1'b1;
    repeat (2) @(negedge clk);
    f0 = n_ferr; v0 = n_valid;
    wire_bit = 1'b0; @(negedge clk);
    wire_bit = 1'b1; @(negedge clk);
    wire_bit = 1'b1; @(negedge clk);
    repeat (4) @(negedge clk);
    wire_bit = 1'b0; @(negedge clk);
    wire_bit = 1'b0; @(negedge clk);
    wire_bit = 1'b1;
    repeat (4) @(negedge clk);
    check_val("ferr_pulses", 64'(n_ferr - f0), 64'h2);
    check_val("ecnt_two", {56'h0, s_ecnt}, 64'h2);
    check_val("no_cmd_on_err", 64'(n_valid - v0), 64'h0);
    for (int i = 0; i < 300; i++) begin
      wire_bit = 1'b0; @(negedge clk);
      wire_bit = 1'b0; @(negedge clk);
      wire_bit = 1'b1; @(negedge clk);
      wire_bit = 1'b1; @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check_val("ecnt_sat", {56'h0, s_ecnt}, 64'hFF);
    check_val("ferr_pulses_all", 64'(n_ferr - f0), 64'd302);

    // Inverted polarity, 8-bit word, short turnaround
    sel = 2'd2; wire_bit = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(64'h3C, 8, 1'b1);
    expect_cmd(64'h3C);
    wait_tri_fall(2);
    check_val("inv_idle_raw", {63'h0, s_out}, 64'h0);
    @(negedge clk);
    read_frame(8, 1'b1, post, word);
    check_val("inv_post", {60'h0, post}, 64'hE);
    check_val("inv_word", word, 64'h3C);
    finish_turn(2);

    // Reset during response bit 10
    sel = 2'd0; wire_bit = 1'b1;
    @(negedge clk);
    send_frame(64'hCAFEF00D, 32, 1'b0);
    expect_cmd(64'hCAFEF00D);
    wait_tri_fall(128);
    @(negedge clk);
    repeat (4 + 11) @(negedge clk);
    check_val("busy_mid_resp", {63'h0, s_busy}, 64'h1);
    check_val("tri_mid_resp", {63'h0, s_tri}, 64'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals(1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(64'h0F0F1234, 32, 1'b0);
    expect_cmd(64'h0F0F1234);
    wait_tri_fall(128);
    @(negedge clk);
    read_frame(32, 1'b0, post, word);
    check_val("post_rst_word", word, 64'h0F0F1234);
    finish_turn(128);

    // Back-to-back: next frame starts the cycle after IDLE re-entry
    f0 = n_ferr;
    send_frame(64'h55AA33CC, 32, 1'b0);
    expect_cmd(64'h55AA33CC);
    check_val("b2b_no_ferr", 64'(n_ferr - f0), 64'h0);
    wait_tri_fall(128);
    @(negedge clk);
    read_frame(32, 1'b0, post, word);
    check_val("b2b_word", word, 64'h55AA33CC);
    finish_turn(128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
